// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a registered borrow,
// processing a - b LSB first, one bit per clock, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic x, y, bin, d, bnext;

    // Full-subtractor cell on the current LSBs and the carried borrow
    always_comb begin
        x     = a_sr_q[0];
        y     = b_sr_q[0];
        bin   = brw_q;
        d     = x ^ y ^ bin;
        bnext = (~x & y) | (~(x ^ y) & bin);
    end

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        diff_d    = diff_q;
        brw_d     = brw_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_sr_d = {d, diff_sr_q[WIDTH-1:1]};
                a_sr_d    = a_sr_q >> 1;
                b_sr_d    = b_sr_q >> 1;
                brw_d     = bnext;
                cnt_d     = cnt_q + CW'(1);
                // Last bit: publish the result directly from the cell output
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    diff_d   = {d, diff_sr_q[WIDTH-1:1]};
                    borrow_d = bnext;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            diff_q    <= '0;
            brw_q     <= 1'b0;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            diff_sr_q <= diff_sr_d;
            diff_q    <= diff_d;
            brw_q     <= brw_d;
            borrow_q  <= borrow_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed handshake/boundary/reset steps, then random
// operands on WIDTH=8 and WIDTH=13 instances checked against plain modular arithmetic.
module tb_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, start13 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [12:0] a13 = '0, b13 = '0;
    logic        busy8, done8, bo8;
    logic        busy13, done13, bo13;
    logic [7:0]  diff8;
    logic [12:0] diff13;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtractor #(.WIDTH(13)) u13 (
        .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13),
        .busy(busy13), .done(done13), .diff(diff13), .borrow_out(bo13)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Launch one operation on the chosen instance and wait (bounded) for done.
    // lat counts edges from the accepting edge (inclusive) to the done cycle.
    task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output int busy_cyc, output bit got,
                          output logic [31:0] rdiff, output logic rbo);
        @(negedge clk);
        if (w == 8) begin a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1; end
        else        begin a13 = av[12:0]; b13 = bv[12:0]; start13 = 1'b1; end
        @(negedge clk);
        start8 = 1'b0; start13 = 1'b0;
        lat = 0; busy_cyc = 0; got = 1'b0; rdiff = '0; rbo = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if ((w == 8) ? busy8 : busy13) busy_cyc++;
            if ((w == 8) ? done8 : done13) begin
                lat   = i;
                got   = 1'b1;
                rdiff = (w == 8) ? {24'd0, diff8} : {19'd0, diff13};
                rbo   = (w == 8) ? bo8 : bo13;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic op_check(input int w, input logic [31:0] av, input logic [31:0] bv,
                            input bit timing);
        int lat, bc;
        bit got;
        logic [31:0] rd, mask, exp_d;
        logic rb;
        mask  = (32'd1 << w) - 32'd1;
        exp_d = (av - bv) & mask;
        run_op(w, av, bv, lat, bc, got, rd, rb);
        check($sformatf("done_seen w%0d %0d-%0d", w, av, bv), {31'd0, got}, 32'd1);
        $display("op w=%0d a=%0d b=%0d -> diff=%0d borrow=%0b (lat=%0d)", w, av, bv, rd, rb, lat);
        if (got) begin
            check("diff", rd, exp_d);
            check("borrow", {31'd0, rb}, {31'd0, (av < bv)});
            if (timing) begin
                check("latency", lat, w + 1);
                check("busy_cycles", bc, w + 1);
            end
        end
        @(negedge clk);
        check("busy_after_done", {31'd0, (w == 8) ? busy8 : busy13}, 32'd0);
    endtask

    initial begin
        int dones, first_done, second_done;
        logic [31:0] ra, rb;

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_diff", {24'd0, diff8}, 32'd0);
        check("rst_borrow", {31'd0, bo8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed values and boundaries
        op_check(8, 100, 37, 1'b1);
        op_check(8, 5, 9, 1'b1);
        op_check(8, 0, 1, 1'b0);
        op_check(8, 255, 255, 1'b0);
        op_check(8, 0, 0, 1'b0);
        op_check(8, 255, 0, 1'b0);

        // start held high, operands changed mid-RUN: two back-to-back ops
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd50; start8 = 1'b1;
        @(negedge clk);
        dones = 0; first_done = 0; second_done = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 3) begin a8 = 8'd7; b8 = 8'd99; end
            if (done8) begin
                dones++;
                if (dones == 1) begin
                    first_done = i;
                    check("held_diff1", {24'd0, diff8}, 32'd150);
                    check("held_borrow1", {31'd0, bo8}, 32'd0);
                end else begin
                    second_done = i;
                    check("held_diff2", {24'd0, diff8}, 32'd164);
                    check("held_borrow2", {31'd0, bo8}, 32'd1);
                end
                $display("held-start done #%0d at cycle %0d diff=%0d borrow=%0b", dones, i, diff8, bo8);
            end
            if (i == 19) start8 = 1'b0;
            @(negedge clk);
        end
        check("held_first_done_cycle", first_done, 9);
        check("held_second_done_cycle", second_done, 19);
        check("held_done_count", dones, 2);
        check("held_idle_after", {31'd0, busy8}, 32'd0);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd20; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy8}, 32'd0);
        check("mid_rst_done", {31'd0, done8}, 32'd0);
        check("mid_rst_diff", {24'd0, diff8}, 32'd0);
        check("mid_rst_borrow", {31'd0, bo8}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) dones++;
            @(negedge clk);
        end
        check("no_done_after_reset", dones, 0);
        $display("mid-run reset: outputs cleared, no stray done");
        op_check(8, 10, 3, 1'b0);

        // Randomized operands on both widths
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            op_check(8, ra, rb, 1'b0);
        end
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom_range(0, 8191);
            rb = $urandom_range(0, 8191);
            op_check(13, ra, rb, (n < 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
